// File: rtl/gb_apu_frame_sequencer.sv
// APU frame sequencer: divides clk to the frame-step rate and walks the 8-phase
// schedule, emitting one-cycle length, sweep and envelope strobes.
module gb_apu_frame_sequencer #(
    parameter int unsigned DIV_RATIO = 8192
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       apu_en,
    input  logic       div_reset,
    output logic       clk_length_ctr,
    output logic       clk_sweep,
    output logic       clk_envelope,
    output logic [2:0] step,
    output logic       length_phase
);

    localparam int unsigned PreW = (DIV_RATIO > 1) ? $clog2(DIV_RATIO) : 1;
    localparam logic [PreW-1:0] PreMax = PreW'(DIV_RATIO - 1);

    logic [PreW-1:0] pre_q, pre_d;
    logic [2:0]      step_q, step_d;
    logic            len_q, len_d;
    logic            sweep_q, sweep_d;
    logic            env_q, env_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q   <= '0;
            step_q  <= '0;
            len_q   <= 1'b0;
            sweep_q <= 1'b0;
            env_q   <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            step_q  <= step_d;
            len_q   <= len_d;
            sweep_q <= sweep_d;
            env_q   <= env_d;
        end
    end

    // Priority: power-off, then DIV write, then prescaler wrap.
    always_comb begin
        pre_d   = pre_q + 1'b1;
        step_d  = step_q;
        len_d   = 1'b0;
        sweep_d = 1'b0;
        env_d   = 1'b0;
        if (!apu_en) begin
            pre_d  = '0;
            step_d = '0;
        end else if (div_reset) begin
            pre_d = '0;
        end else if (pre_q == PreMax) begin
            pre_d   = '0;
            step_d  = step_q + 3'd1;
            len_d   = ~step_q[0];
            sweep_d = (step_q[1:0] == 2'b10);
            env_d   = (step_q == 3'd7);
        end
    end

    assign clk_length_ctr = len_q;
    assign clk_sweep      = sweep_q;
    assign clk_envelope   = env_q;
    assign step           = step_q;
    assign length_phase   = ~step_q[0];

endmodule
